// File: rtl/ahb_lite_mem_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_lite_mem_slave_if
// Bus bundle between an AHB-Lite master (or the interconnect) and
// ahb_lite_mem_slave.
//
// Signals
//   Hsel       slave select
//   Haddr      byte address (address phase)
//   Htrans     IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   Hwrite     1 = write, 0 = read
//   Hsize      0 = byte, 1 = half, 2 = word
//   Hburst     burst type (carried, not interpreted by the slave)
//   Hwdata     write data (data phase)
//   Hready_in  bus HREADY, 1 = previous data phase complete
//   Hready_out slave ready, 0 = extend data phase
//   Hresp      0 = OKAY, 1 = ERROR
//   Hrdata     read data
//
// Modports: master (drives request side), slave (drives response side).
// Width macros are defined here if the build has not already defined them.
// ---------------------------------------------------------------------------
`ifndef HADDR_WIDTH
`define HADDR_WIDTH 32
`endif
`ifndef HTRANS_WIDTH
`define HTRANS_WIDTH 2
`endif
`ifndef HSIZE_WIDTH
`define HSIZE_WIDTH 3
`endif
`ifndef HBURST_WIDTH
`define HBURST_WIDTH 3
`endif
`ifndef HWDATA_WIDTH
`define HWDATA_WIDTH 32
`endif
`ifndef HRDATA_WIDTH
`define HRDATA_WIDTH 32
`endif

interface ahb_lite_mem_slave_if;
  logic                       Hsel;
  logic [`HADDR_WIDTH-1:0]    Haddr;
  logic [`HTRANS_WIDTH-1:0]   Htrans;
  logic                       Hwrite;
  logic [`HSIZE_WIDTH-1:0]    Hsize;
  logic [`HBURST_WIDTH-1:0]   Hburst;
  logic [`HWDATA_WIDTH-1:0]   Hwdata;
  logic                       Hready_in;
  logic                       Hready_out;
  logic                       Hresp;
  logic [`HRDATA_WIDTH-1:0]   Hrdata;

  modport master (
    output Hsel, Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hready_in,
    input  Hready_out, Hresp, Hrdata
  );

  modport slave (
    input  Hsel, Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hready_in,
    output Hready_out, Hresp, Hrdata
  );
endinterface

// File: rtl/ahb_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_mem_slave
// AHB-Lite word-organised memory slave with configurable wait states,
// little-endian byte/halfword writes, alignment checking and a two-cycle
// ERROR response.
//
// Parameters
//   MEM_DEPTH    number of 32-bit words (power of two)
//   WAIT_STATES  wait cycles inserted before each OKAY data phase (0..7)
//
// Ports
//   hclk    clock, rising edge
//   hreset  asynchronous active-high reset
//   bus     ahb_lite_mem_slave_if.slave (Hsel, Haddr, Htrans, Hwrite, Hsize,
//           Hburst, Hwdata, Hready_in in; Hready_out, Hresp, Hrdata out)
//
// Configuration macro
//   AHB_SLV_RANGE_ERR_EN  defined: addresses >= 4*MEM_DEPTH give an ERROR
//                         response. Undefined: they give OKAY, writes are
//                         dropped and reads return zero.
//
// Memory contents are not reset.
// ---------------------------------------------------------------------------
`ifndef HADDR_WIDTH
`define HADDR_WIDTH 32
`endif

module ahb_lite_mem_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                 hclk,
  input  logic                 hreset,
  ahb_lite_mem_slave_if.slave  bus
);

  localparam int         AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [0:MEM_DEPTH-1];

  logic [AW-1:0] widx_p1;
  logic [1:0]    boff_p1;
  logic [2:0]    hsize_p1;
  logic          hwrite_p1;
  logic          oor_p1;
  logic [2:0]    wcnt;
  logic [3:0]    be_p1;

  logic          slot_open;
  logic          accept;
  logic          misalign;
  logic          oor_now;
  logic          acc_err;
  logic          wr_en;
  state_t        start_st;

  logic          unused_bits;
  assign unused_bits = ^{bus.Hburst, bus.Htrans[0]};

  // The slave can only take a new address phase when its own data phase is
  // finishing (or there is none); this also guards against a misbehaving
  // Hready_in during WAIT/ERR1.
  assign slot_open = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept    = bus.Hsel & bus.Hready_in & bus.Htrans[1] & slot_open;
  assign oor_now   = |bus.Haddr[`HADDR_WIDTH-1:AW+2];

  always_comb begin
    misalign = 1'b0;
    case (bus.Hsize)
      3'd0:    misalign = 1'b0;
      3'd1:    misalign = bus.Haddr[0];
      3'd2:    misalign = |bus.Haddr[1:0];
      default: misalign = 1'b1;
    endcase
  end

`ifdef AHB_SLV_RANGE_ERR_EN
  assign acc_err = misalign | oor_now;
`else
  assign acc_err = misalign;
`endif

  assign start_st = acc_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);

  // ---- address phase -> data phase boundary (state + latched fields) ----
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= S_IDLE;
      widx_p1   <= '0;
      boff_p1   <= '0;
      hsize_p1  <= '0;
      hwrite_p1 <= 1'b0;
      oor_p1    <= 1'b0;
      wcnt      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        widx_p1   <= bus.Haddr[AW+1:2];
        boff_p1   <= bus.Haddr[1:0];
        hsize_p1  <= bus.Hsize;
        hwrite_p1 <= bus.Hwrite;
        oor_p1    <= oor_now;
      end
      // Counter runs only inside WAIT and is zero on every WAIT entry.
      if (state == S_WAIT) wcnt <= wcnt + 3'd1;
      else                 wcnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = accept ? start_st : S_IDLE;
      S_WAIT:  state_nxt = (wcnt == WS_LAST) ? S_DATA : S_WAIT;
      S_DATA:  state_nxt = accept ? start_st : S_IDLE;
      S_ERR1:  state_nxt = S_ERR2;
      S_ERR2:  state_nxt = accept ? start_st : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read data comes straight from the array during DATA. A read accepted on
  // the edge that commits a write DATA phase therefore already sees the new
  // bytes, which provides the write-to-read forwarding.
  always_comb begin
    bus.Hready_out = 1'b1;
    bus.Hresp      = 1'b0;
    bus.Hrdata     = '0;
    case (state)
      S_WAIT: bus.Hready_out = 1'b0;
      S_DATA: if (!hwrite_p1 && !oor_p1) bus.Hrdata = mem[widx_p1];
      S_ERR1: begin
        bus.Hready_out = 1'b0;
        bus.Hresp      = 1'b1;
      end
      S_ERR2: bus.Hresp = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    be_p1 = 4'b1111;
    case (hsize_p1)
      3'd0:    be_p1 = 4'b0001 << boff_p1;
      3'd1:    be_p1 = boff_p1[1] ? 4'b1100 : 4'b0011;
      default: be_p1 = 4'b1111;
    endcase
  end

  // ---- data phase commit (end of DATA) ----
  assign wr_en = (state == S_DATA) && hwrite_p1 && !oor_p1;

  always_ff @(posedge hclk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_p1[b]) mem[widx_p1][8*b +: 8] <= bus.Hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/ahb_lite_mem_slave.md
AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of 32-bit words; must be a power of two.
REQ-002 Parameter WAIT_STATES, default 0: wait cycles inserted per OKAY data phase; legal range 0..7.
REQ-003 Port hclk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port hreset, input, 1: reset, asynchronous and active-high.
REQ-005 Port Hsel, input, 1: slave select.
REQ-006 Port Haddr, input, `HADDR_WIDTH: byte address.
REQ-007 Port Htrans, input, `HTRANS_WIDTH: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 Port Hwrite, input, 1: 1 = write, 0 = read.
REQ-009 Port Hsize, input, `HSIZE_WIDTH: 0 = byte, 1 = half, 2 = word.
REQ-010 Port Hburst, input, `HBURST_WIDTH: accepted; does not affect behaviour.
REQ-011 Port Hwdata, input, `HWDATA_WIDTH (32): write data, valid in the data phase.
REQ-012 Port Hready_in, input, 1: bus HREADY; 1 = previous data phase complete.
REQ-013 Port Hready_out, output, 1: slave ready; 0 = extend the data phase.
REQ-014 Port Hresp, output, 1: 0 = OKAY, 1 = ERROR.
REQ-015 Port Hrdata, output, `HRDATA_WIDTH (32): read data.

Function
REQ-016 Address phase accepted on a rising edge iff Hsel && Hready_in && Htrans[1]; latches word index Haddr[log2(MEM_DEPTH)+1:2], Haddr[1:0], Hsize, Hwrite.
REQ-017 IDLE, BUSY, or unselected cycles: no state change; Hready_out=1, Hresp=0 on the following cycle.
REQ-018 FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
REQ-019 Accepted OKAY transfer: goes to WAIT when WAIT_STATES>0, otherwise to DATA.
REQ-020 WAIT: Hready_out=0 for exactly WAIT_STATES cycles, then DATA.
REQ-021 DATA: Hready_out=1, Hresp=0, for exactly one cycle.
REQ-022 From DATA: a new accepted address phase goes to WAIT or DATA; otherwise the FSM returns to IDLE.
REQ-023 Write: the memory is updated at the end of DATA with Hwdata.
REQ-024 Write byte lanes are little-endian, selected by Hsize and the latched Haddr[1:0]; other bytes are unchanged.
REQ-025 Read: Hrdata = full 32-bit word at the latched index during DATA; Hrdata=0 in all other states.
REQ-026 A read whose address phase coincides with a write DATA phase to the same word returns the newly written bytes (forwarding).
REQ-027 Misaligned address (Haddr % 2**Hsize != 0) or Hsize>2 is an error transfer.
REQ-028 Error transfer: never writes memory.
REQ-029 Error response sequence: ERR1 (Hready_out=0, Hresp=1), then ERR2 (Hready_out=1, Hresp=1), then IDLE or a newly accepted transfer.
REQ-030 Error transfers have no wait states; WAIT_STATES applies to OKAY transfers only.
REQ-031 An address phase presented while Hready_in=0 is ignored.

Reset
REQ-032 While hreset=1: FSM=IDLE, Hready_out=1, Hresp=0, Hrdata=0, all latched address-phase registers cleared.
REQ-033 Memory contents are not reset.
REQ-034 Reset asserted mid-transfer aborts it: a pending write is discarded and the first edge after deassertion behaves as IDLE.

Configuration
REQ-035 Macro AHB_SLV_RANGE_ERR_EN defined: an address at or beyond 4*MEM_DEPTH bytes is an error transfer (REQ-029).
REQ-036 Macro AHB_SLV_RANGE_ERR_EN undefined: out-of-range address gives an OKAY response; writes are dropped and reads return 0.
REQ-037 AHB_SLV_RANGE_ERR_EN undefined: misaligned addresses and Hsize>2 remain errors (REQ-027).

Verification
REQ-038 WAIT_STATES=0, write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> read DATA cycle Hrdata=0xDEADBEEF, Hready_out=1, Hresp=0.
REQ-039 WAIT_STATES=3, single read of 0x04 -> Hready_out low for exactly 3 cycles, then high with Hresp=0 and correct data.
REQ-040 Byte write 0xAA to 0x13 over word 0x11223344 at 0x10 -> read 0x10 returns 0xAA223344.
REQ-041 Word access to 0x02 -> cycle 1: Hready_out=0, Hresp=1; cycle 2: Hready_out=1, Hresp=1; memory unchanged.
REQ-042 With AHB_SLV_RANGE_ERR_EN, MEM_DEPTH=256, read 0x400 -> two-cycle ERROR; without the macro -> OKAY with Hrdata=0.
REQ-043 hreset asserted during WAIT of a write to 0x20 -> outputs immediately at reset values, and a later read of 0x20 returns its prior content.
